order_msg_gate: RTL and testbench

ORDER_MSG_GATE -- requirements
Module: order_msg_gate

---
 rtl/order_msg_gate.sv | 227 ++++++++++++++++++++++
 tb/tb_order_msg_gate.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_msg_gate.sv
// order_msg_gate: admits fixed 3-beat / 80-byte messages into a 16-entry beat
// buffer, validates length, framing and checksum, and forwards only complete
// valid messages through a registered output stage.
module order_msg_gate (
  input  logic         clk,
  input  logic         resetn,
  input  logic [255:0] s_tdata,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  input  logic [31:0]  s_tkeep,
  output logic         s_tready,
  output logic [255:0] m_tdata,
  output logic         m_tvalid,
  output logic         m_tlast,
  output logic [31:0]  m_tkeep,
  input  logic         m_tready,
  output logic [15:0]  ok_cnt,
  output logic [15:0]  bad_cnt,
  output logic [15:0]  drop_cnt
);

  localparam logic [15:0] MSG_LEN   = 16'd77;
  localparam logic [31:0] KEEP_FULL = 32'hFFFF_FFFF;
  localparam logic [31:0] KEEP_TAIL = 32'h0000_FFFF;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} rx_state_t;

  rx_state_t    state, state_nx;
  logic [1:0]   beat_idx, beat_idx_nx;
  logic [7:0]   csum, csum_nx;
  logic         len_bad, len_bad_nx;
  logic         drop_mode, drop_mode_nx;
  logic         wr_en, do_commit, do_rewind;
  logic         ok_inc, bad_inc, drop_inc;
  logic [4:0]   rd, wr_commit, wr_spec;
  logic [4:0]   free;
  logic         admit;
  logic [1:0]   out_beat;
  logic [255:0] mem [16];
  logic [7:0]   full_sum, tail_sum, msg_sum;
  logic         unused_keep;

  // Sum of the lowest n bytes of a beat, modulo 256.
  function automatic logic [7:0] byte_sum(input logic [255:0] d, input int n);
    logic [7:0] acc;
    acc = '0;
    for (int k = 0; k < 32; k++)
      if (k < n) acc = acc + d[8*k +: 8];
    return acc;
  endfunction

  // Keep is ignored: every beat is treated as full.
  assign unused_keep = ^s_tkeep;

  assign free     = 5'd16 - (wr_commit - rd);
  assign admit    = (free >= 5'd3);
  assign s_tready = admit;

  // Beats 0/1 contribute all 32 bytes; beat 2 contributes bytes 64..78 only.
  assign full_sum = byte_sum(s_tdata, 32);
  assign tail_sum = byte_sum(s_tdata, 15);
  assign msg_sum  = csum + tail_sum;

  // Receive FSM state register and per-message accumulators.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state     <= IDLE;
      beat_idx  <= 2'd0;
      csum      <= 8'd0;
      len_bad   <= 1'b0;
      drop_mode <= 1'b0;
    end else begin
      state     <= state_nx;
      beat_idx  <= beat_idx_nx;
      csum      <= csum_nx;
      len_bad   <= len_bad_nx;
      drop_mode <= drop_mode_nx;
    end
  end

  // Receive FSM next-state and write/commit/rewind strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nx     = state;
    beat_idx_nx  = beat_idx;
    csum_nx      = csum;
    len_bad_nx   = len_bad;
    drop_mode_nx = drop_mode;
    wr_en        = 1'b0;
    do_commit    = 1'b0;
    do_rewind    = 1'b0;
    ok_inc       = 1'b0;
    bad_inc      = 1'b0;
    drop_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (s_tvalid) begin
          if (!admit) begin
            // No room for a full message: swallow it without writing.
            if (s_tlast) begin
              drop_inc = 1'b1;
            end else begin
              state_nx     = DISCARD;
              drop_mode_nx = 1'b1;
            end
          end else begin
            wr_en      = 1'b1;
            csum_nx    = full_sum;
            len_bad_nx = (s_tdata[15:0] != MSG_LEN);
            if (s_tlast) begin
              bad_inc   = 1'b1;
              do_rewind = 1'b1;
            end else begin
              state_nx    = RECV;
              beat_idx_nx = 2'd1;
            end
          end
        end
      end
      RECV: begin
        if (s_tvalid) begin
          wr_en = 1'b1;
          if (beat_idx == 2'd1) begin
            csum_nx = csum + full_sum;
            if (s_tlast) begin
              bad_inc   = 1'b1;
              do_rewind = 1'b1;
              state_nx  = IDLE;
            end else begin
              beat_idx_nx = 2'd2;
            end
          end else if (s_tlast) begin
            state_nx = IDLE;
            if (!len_bad && (msg_sum == s_tdata[127:120])) begin
              do_commit = 1'b1;
              ok_inc    = 1'b1;
            end else begin
              bad_inc   = 1'b1;
              do_rewind = 1'b1;
            end
          end else begin
            // Over-long frame: the written beats are rewound at close.
            state_nx     = DISCARD;
            drop_mode_nx = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (s_tvalid && s_tlast) begin
          state_nx = IDLE;
          if (drop_mode) begin
            drop_inc = 1'b1;
          end else begin
            bad_inc   = 1'b1;
            do_rewind = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat storage.
  always_ff @(posedge clk) begin
    // NOTE: the buffer array has no reset; the pointers alone decide which
    // entries are meaningful, so clearing the data would be wasted logic.
    if (wr_en) mem[wr_spec[3:0]] <= s_tdata;
  end

  // Write pointers: speculative advance, commit on valid close, rewind on bad.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_spec   <= 5'd0;
      wr_commit <= 5'd0;
    end else if (do_rewind) begin
      wr_spec <= wr_commit;
    end else if (do_commit) begin
      wr_spec   <= wr_spec + 5'd1;
      wr_commit <= wr_spec + 5'd1;
    end else if (wr_en) begin
      wr_spec <= wr_spec + 5'd1;
    end
  end

  // Saturating message counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ok_cnt   <= 16'd0;
      bad_cnt  <= 16'd0;
      drop_cnt <= 16'd0;
    end else begin
      if (ok_inc && (ok_cnt != CNT_MAX))     ok_cnt   <= ok_cnt + 16'd1;
      if (bad_inc && (bad_cnt != CNT_MAX))   bad_cnt  <= bad_cnt + 16'd1;
      if (drop_inc && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Registered output stage; committed messages are always whole, so a
  // running beat counter identifies beat 2 of each message.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd       <= 5'd0;
      out_beat <= 2'd0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
    end else if (!m_tvalid || m_tready) begin
      if (rd != wr_commit) begin
        m_tvalid <= 1'b1;
        m_tdata  <= mem[rd[3:0]];
        m_tlast  <= (out_beat == 2'd2);
        m_tkeep  <= (out_beat == 2'd2) ? KEEP_TAIL : KEEP_FULL;
        rd       <= rd + 5'd1;
        out_beat <= (out_beat == 2'd2) ? 2'd0 : out_beat + 2'd1;
      end else begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_order_msg_gate.sv
// Bench for order_msg_gate: random messages checked against a message-level
// model (byte sums, frame shape, expected-beat queue) plus directed scenarios.
module tb_order_msg_gate;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [255:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic [31:0]  s_tkeep = '0;
  logic         s_tready;
  logic [255:0] m_tdata;
  logic         m_tvalid;
  logic         m_tlast;
  logic [31:0]  m_tkeep;
  logic         m_tready = 1'b0;
  logic [15:0]  ok_cnt, bad_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] data;
    logic         last;
    logic [31:0]  keep;
  } beat_t;

  typedef enum {RDY_HOLD, RDY_RANDOM, RDY_TOGGLE} rdy_mode_t;

  beat_t     exp_q[$];
  beat_t     mon_exp;
  beat_t     held;
  logic      held_valid = 1'b0;
  int        accepted = 0;
  int        m_ok = 0, m_bad = 0, m_drop = 0;
  rdy_mode_t rdy_mode = RDY_HOLD;

  order_msg_gate dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tkeep  (s_tkeep),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tkeep  (m_tkeep),
    .m_tready (m_tready),
    .ok_cnt   (ok_cnt),
    .bad_cnt  (bad_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Output monitor: every accepted beat must be the next expected one, and a
  // stalled beat must not change until accepted.
  always @(negedge clk) begin
    if (resetn !== 1'b1) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== held.data || m_tlast !== held.last || m_tkeep !== held.keep) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b last=%b keep=%h data=%h, held last=%b keep=%h data=%h",
                   m_tvalid, m_tlast, m_tkeep, m_tdata, held.last, held.keep, held.data);
        end
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got last=%b data=%h, no beat expected", m_tlast, m_tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (m_tdata !== mon_exp.data || m_tlast !== mon_exp.last || m_tkeep !== mon_exp.keep) begin
            errors++;
            $display("FAIL out_beat: got last=%b keep=%h data=%h, expected last=%b keep=%h data=%h",
                     m_tlast, m_tkeep, m_tdata, mon_exp.last, mon_exp.keep, mon_exp.data);
          end
        end
        accepted++;
        held_valid = 1'b0;
      end else if (m_tvalid === 1'b1) begin
        held_valid = 1'b1;
        held.data  = m_tdata;
        held.last  = m_tlast;
        held.keep  = m_tkeep;
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      RDY_RANDOM: m_tready = 1'($urandom_range(0, 1));
      RDY_TOGGLE: m_tready = ~m_tready;
      default: ;
    endcase
  endtask

  // A random 80-byte message with the given length field and a correct checksum.
  function automatic logic [767:0] build_msg(input logic [15:0] len);
    logic [767:0] m;
    logic [7:0]   s;
    for (int i = 0; i < 24; i++) m[32*i +: 32] = $urandom;
    m[15:0] = len;
    s = '0;
    for (int k = 0; k < 79; k++) s = s + m[8*k +: 8];
    m[639:632] = s;
    return m;
  endfunction

  function automatic bit msg_valid(input logic [767:0] m, input int nbeats);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < 79; k++) s = s + m[8*k +: 8];
    return (nbeats == 3) && (m[15:0] == 16'd77) && (s == m[639:632]);
  endfunction

  // Drive one frame of nbeats (tlast on the final beat) and update the model.
  task automatic send_frame(input logic [767:0] m, input int nbeats, input bit admit, input bit gaps);
    beat_t        b;
    logic [255:0] extra;
    if (!admit) begin
      m_drop++;
    end else if (msg_valid(m, nbeats)) begin
      m_ok++;
      for (int i = 0; i < 3; i++) begin
        b.data = m[256*i +: 256];
        b.last = (i == 2);
        b.keep = (i == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        exp_q.push_back(b);
      end
    end else begin
      m_bad++;
    end
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_tvalid = 1'b0;
          tick();
        end
      end
      for (int w = 0; w < 8; w++) extra[32*w +: 32] = $urandom;
      s_tvalid = 1'b1;
      s_tdata  = (i < 3) ? m[256*i +: 256] : extra;
      s_tlast  = (i == nbeats - 1);
      s_tkeep  = $urandom;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles", name, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b last=%b keep=%h data=%h, expected all 0",
               m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    checks++;
    if ({ok_cnt, bad_cnt, drop_cnt} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counters: got ok=%0d bad=%0d drop=%0d, expected 0 0 0", ok_cnt, bad_cnt, drop_cnt);
    end
    resetn = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_tready: got %b, expected 1", s_tready);
    end
  endtask

  task automatic test_single_valid();
    logic [767:0] m;
    rdy_mode = RDY_HOLD;
    m_tready = 1'b1;
    m = build_msg(16'd77);
    send_frame(m, 3, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_commit_edge: got m_tvalid=%b, expected 0", m_tvalid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== m[256*i +: 256]) begin
        errors++;
        $display("FAIL latency_beat%0d: got valid=%b data=%h, expected valid=1 data=%h",
                 i, m_tvalid, m_tdata, m[256*i +: 256]);
      end
    end
    drain("single");
    checks++;
    if ({ok_cnt, bad_cnt, drop_cnt} !== {m_ok[15:0], m_bad[15:0], m_drop[15:0]}) begin
      errors++;
      $display("FAIL single_counters: got ok=%0d bad=%0d drop=%0d, expected %0d %0d %0d",
               ok_cnt, bad_cnt, drop_cnt, m_ok, m_bad, m_drop);
    end
  endtask

  task automatic test_bad_checksum();
    logic [767:0] m;
    bit           seen;
    m_tready = 1'b1;
    m = build_msg(16'd77);
    m[639:632] = m[639:632] + 8'd1;
    send_frame(m, 3, 1'b1, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_tvalid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bad_csum_no_output: got m_tvalid=1, expected 0");
    end
    send_frame(build_msg(16'd77), 3, 1'b1, 1'b1);
    drain("bad_csum");
    checks++;
    if ({ok_cnt, bad_cnt, drop_cnt} !== {m_ok[15:0], m_bad[15:0], m_drop[15:0]}) begin
      errors++;
      $display("FAIL bad_csum_counters: got ok=%0d bad=%0d drop=%0d, expected %0d %0d %0d",
               ok_cnt, bad_cnt, drop_cnt, m_ok, m_bad, m_drop);
    end
  endtask

  task automatic test_early_tlast();
    int start;
    m_tready = 1'b1;
    start = accepted;
    send_frame(build_msg(16'd77), 2, 1'b1, 1'b0);
    send_frame(build_msg(16'd77), 3, 1'b1, 1'b0);
    drain("early_tlast");
    checks++;
    if (accepted - start != 3) begin
      errors++;
      $display("FAIL early_tlast_beats: got %0d beats, expected 3", accepted - start);
    end
    checks++;
    if ({ok_cnt, bad_cnt, drop_cnt} !== {m_ok[15:0], m_bad[15:0], m_drop[15:0]}) begin
      errors++;
      $display("FAIL early_tlast_counters: got ok=%0d bad=%0d drop=%0d, expected %0d %0d %0d",
               ok_cnt, bad_cnt, drop_cnt, m_ok, m_bad, m_drop);
    end
  endtask

  task automatic test_fill_drop();
    int start;
    rdy_mode = RDY_HOLD;
    m_tready = 1'b0;
    start = accepted;
    // Back to back: five fit, the sixth finds fewer than three free entries.
    for (int i = 0; i < 6; i++) send_frame(build_msg(16'd77), 3, (i < 5), 1'b0);
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (drop_cnt !== 16'(m_drop) || ok_cnt !== 16'(m_ok)) begin
      errors++;
      $display("FAIL fill_counters: got ok=%0d drop=%0d, expected %0d %0d", ok_cnt, drop_cnt, m_ok, m_drop);
    end
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL fill_s_tready: got %b, expected 0", s_tready);
    end
    m_tready = 1'b1;
    drain("fill");
    checks++;
    if (accepted - start != 15) begin
      errors++;
      $display("FAIL fill_beats: got %0d beats, expected 15", accepted - start);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL fill_s_tready_after: got %b, expected 1", s_tready);
    end
  endtask

  task automatic test_stall_toggle();
    int start;
    start = accepted;
    rdy_mode = RDY_TOGGLE;
    for (int i = 0; i < 3; i++) send_frame(build_msg(16'd77), 3, 1'b1, 1'b1);
    drain("toggle");
    rdy_mode = RDY_HOLD;
    checks++;
    if (accepted - start != 9) begin
      errors++;
      $display("FAIL toggle_beats: got %0d beats, expected 9", accepted - start);
    end
  endtask

  task automatic test_reset_mid();
    logic [767:0] m;
    int           start;
    rdy_mode = RDY_HOLD;
    m_tready = 1'b0;
    send_frame(build_msg(16'd77), 3, 1'b1, 1'b0);
    m = build_msg(16'd77);
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = m[256*i +: 256];
      s_tlast  = 1'b0;
      tick();
    end
    s_tvalid = 1'b0;
    resetn   = 1'b0;
    exp_q.delete();
    m_ok = 0;
    m_bad = 0;
    m_drop = 0;
    tick();
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata, ok_cnt, bad_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_zero: got valid=%b last=%b keep=%h ok=%0d bad=%0d drop=%0d, expected all 0",
               m_tvalid, m_tlast, m_tkeep, ok_cnt, bad_cnt, drop_cnt);
    end
    resetn = 1'b1;
    m_tready = 1'b1;
    tick();
    start = accepted;
    send_frame(build_msg(16'd77), 3, 1'b1, 1'b0);
    drain("reset_mid");
    checks++;
    if (accepted - start != 3) begin
      errors++;
      $display("FAIL reset_mid_beats: got %0d beats, expected 3", accepted - start);
    end
    checks++;
    if ({ok_cnt, bad_cnt, drop_cnt} !== {m_ok[15:0], m_bad[15:0], m_drop[15:0]}) begin
      errors++;
      $display("FAIL reset_mid_counters: got ok=%0d bad=%0d drop=%0d, expected %0d %0d %0d",
               ok_cnt, bad_cnt, drop_cnt, m_ok, m_bad, m_drop);
    end
  endtask

  task automatic test_random();
    logic [767:0] m;
    int           kind, nbeats, n;
    rdy_mode = RDY_RANDOM;
    for (int t = 0; t < 40; t++) begin
      // Keep the buffer well below full so every message is admitted.
      n = 0;
      while (exp_q.size() > 9 && n < 400) begin
        tick();
        n++;
      end
      checks++;
      if (exp_q.size() > 9) begin
        errors++;
        $display("FAIL random_backlog: %0d beats pending after %0d cycles, expected <= 9", exp_q.size(), n);
      end
      kind   = $urandom_range(0, 6);
      nbeats = 3;
      m      = build_msg(16'd77);
      case (kind)
        3: m[639:632] = m[639:632] ^ 8'(1 << $urandom_range(0, 7));
        4: m = build_msg(16'd77 + 16'($urandom_range(1, 200)));
        5: nbeats = $urandom_range(1, 2);
        6: nbeats = $urandom_range(4, 5);
        default: ;
      endcase
      send_frame(m, nbeats, 1'b1, 1'($urandom_range(0, 1)));
    end
    rdy_mode = RDY_HOLD;
    m_tready = 1'b1;
    drain("random");
    checks++;
    if ({ok_cnt, bad_cnt, drop_cnt} !== {m_ok[15:0], m_bad[15:0], m_drop[15:0]}) begin
      errors++;
      $display("FAIL random_counters: got ok=%0d bad=%0d drop=%0d, expected %0d %0d %0d",
               ok_cnt, bad_cnt, drop_cnt, m_ok, m_bad, m_drop);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_valid();
    test_bad_checksum();
    test_early_tlast();
    test_fill_drop();
    test_stall_toggle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
